// File: rtl/bsg_wormhole_packet_parser_multi_pkg.sv
// bsg_wormhole_packet_parser_multi_pkg: shared state encoding for the wormhole packet parser
package bsg_wormhole_packet_parser_multi_pkg;

    typedef enum logic {
        e_idle,
        e_body
    } parser_state_e;

endpackage

// File: rtl/bsg_wormhole_packet_parser_multi_if.sv
// bsg_wormhole_packet_parser_multi_if: fifo head-flit signals and parser classification outputs
interface bsg_wormhole_packet_parser_multi_if #(
    parameter int payload_len_bits_p = 4
);
    logic                          fifo_v_i;
    logic [payload_len_bits_p-1:0] fifo_payload_len_i;
    logic                          fifo_yumi_i;
    logic                          expecting_header_r_o;
    logic                          first_flit_o;
    logic                          hdr_flit_o;
    logic                          last_flit_o;
    logic [payload_len_bits_p-1:0] flit_idx_o;
    logic                          len_error_o;

    modport master (
        output fifo_v_i, fifo_payload_len_i, fifo_yumi_i,
        input  expecting_header_r_o, first_flit_o, hdr_flit_o, last_flit_o, flit_idx_o, len_error_o
    );

    modport slave (
        input  fifo_v_i, fifo_payload_len_i, fifo_yumi_i,
        output expecting_header_r_o, first_flit_o, hdr_flit_o, last_flit_o, flit_idx_o, len_error_o
    );
endinterface

// File: rtl/bsg_wormhole_packet_parser_multi_counter_set_down.sv
// bsg_wormhole_packet_parser_multi_counter_set_down: loadable down-counter for flits remaining in a packet
module bsg_wormhole_packet_parser_multi_counter_set_down #(
    parameter int width_p = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [width_p-1:0] val,
    input  logic               down,
    output logic [width_p-1:0] count
);
    // load has priority over decrement; the parser never asserts both
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (set) count <= val;
        else if (down) count <= count - width_p'(1);
    end
endmodule

// File: rtl/bsg_wormhole_packet_parser_multi.sv
// bsg_wormhole_packet_parser_multi: classifies the fifo head flit as first/header/data/last within a wormhole packet
module bsg_wormhole_packet_parser_multi
    import bsg_wormhole_packet_parser_multi_pkg::*;
#(
    parameter int payload_len_bits_p = 4,
    parameter int hdr_flits_p        = 1
) (
    input logic clk_i,
    input logic reset_i,
    bsg_wormhole_packet_parser_multi_if.slave bus
);
    localparam int lw = payload_len_bits_p;
    localparam logic [lw-1:0] min_len = lw'(hdr_flits_p - 1);
    localparam logic [lw:0] hdr_flits = (lw+1)'(hdr_flits_p);

    parser_state_e state_r, state_n;
    logic [lw-1:0] idx_r, remaining;
    logic          len_error_r;

    // a yumi without a valid flit is ignored so it can never corrupt the state
    wire deq      = bus.fifo_yumi_i & bus.fifo_v_i;
    wire idle     = state_r == e_idle;
    wire len_zero = bus.fifo_payload_len_i == '0;
    wire rem_one  = remaining == lw'(1);
    wire idle_deq = idle & deq;
    wire body_deq = !idle & deq;

    bsg_wormhole_packet_parser_multi_counter_set_down #(.width_p(lw)) remaining_cnt (
        .clk   (clk_i),
        .rst   (reset_i),
        .set   (idle_deq),
        .val   (bus.fifo_payload_len_i),
        .down  (body_deq),
        .count (remaining)
    );

    // state, flit index and the one-cycle length-error pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            idx_r       <= '0;
            len_error_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            len_error_r <= idle_deq & (bus.fifo_payload_len_i < min_len);
            if (idle_deq) idx_r <= len_zero ? '0 : lw'(1);
            else if (body_deq) idx_r <= rem_one ? '0 : idx_r + lw'(1);
        end
    end

    // leave idle on a multi-flit first flit, return after the last body flit
    always_comb begin
        state_n = state_r;
        if (idle_deq && !len_zero) state_n = e_body;
        if (body_deq && rem_one) state_n = e_idle;
    end

    // zero-latency classification of the head flit
    always_comb begin
        bus.expecting_header_r_o = idle;
        bus.first_flit_o         = bus.fifo_v_i & idle;
        bus.flit_idx_o           = idle ? '0 : idx_r;
        bus.last_flit_o          = bus.fifo_v_i & (idle ? len_zero : rem_one);
        bus.hdr_flit_o           = bus.fifo_v_i & (idle | ({1'b0, idx_r} < hdr_flits));
        bus.len_error_o          = len_error_r;
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) bus.fifo_yumi_i |-> bus.fifo_v_i);
endmodule
